fake_netlist_pattern_driver: RTL and testbench
==============================================

# fake_netlist_pattern_driver

Stimulus/response partner for the generated combinational netlists: a sequential pattern driver that feeds 27-bit pseudo-random vectors into a netlist's primary inputs (n_0..n_26) and compacts its single primary output (n_89-style) into a signature. It sits on the test side of every 27-in/1-out fake netlist, so a build can be checked against a golden signature instead of per-vector waveforms.

## Interface
- NUM_PATTERNS, 256, vectors applied per run (>=1)
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling the response (>=0)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; honoured only in IDLE or DONE
- abort  input  1  terminate run, return to IDLE
- seed_load  input  1  load seed into seed register; honoured only in IDLE or DONE
- seed  input  27  LFSR seed value
- pat_out  output  27  registered vector; bit i drives netlist input n_i
- resp_in  input  1  netlist output under test
- busy  output  1  high in APPLY/SETTLE/CAPTURE
- done  output  1  high in DONE
- signature  output  16  response signature
- ones_count  output  clog2(NUM_PATTERNS+1)  number of sampled 1s

## Operation
- Reset: state IDLE; pat_out=0, busy=0, done=0, signature=0, ones_count=0, seed register=27'h0000001, pattern counter=0.
- seed_load: seed register <= seed; an all-zero seed is stored as 27'h0000001 (LFSR lockup guard). If seed_load and start coincide, the new seed is used for that run.
- LFSR: 27-bit Fibonacci, polynomial x^27+x^5+x^2+x+1; step = {lfsr[25:0], lfsr[26]^lfsr[4]^lfsr[1]^lfsr[0]}.
- Signature: CRC-16 poly 0x1021, serial MSB-first, init 0; per sample fb=sig[15]^resp_in, sig <= {sig[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- States:
  - IDLE: outputs hold. start -> APPLY; lfsr <= seed reg, signature <= 0, ones_count <= 0, counter <= 0.
  - APPLY: pat_out <= lfsr; settle counter <= SETTLE_CYCLES; -> SETTLE (or CAPTURE if SETTLE_CYCLES=0).
  - SETTLE: decrement; at 1 -> CAPTURE.
  - CAPTURE: sample resp_in, update signature and ones_count, step lfsr; if counter==NUM_PATTERNS-1 -> DONE else counter++ and -> APPLY.
  - DONE: done=1; signature/ones_count/pat_out hold. start -> new run as from IDLE.
- abort in any busy state: -> IDLE next edge; signature and ones_count keep their partial values; done stays 0. abort has priority over CAPTURE completion. abort in IDLE/DONE: -> IDLE.
- start while busy: ignored.
- rst_n low mid-run: immediate return to reset values; no partial done.

## Timing
- start sampled at edge T0 -> APPLY during T0..T1; pat_out shows vector 0 after edge T1.
- Per vector: 1 APPLY + SETTLE_CYCLES SETTLE + 1 CAPTURE = SETTLE_CYCLES+2 cycles.
- resp_in sampled in CAPTURE, i.e. SETTLE_CYCLES+1 cycles after pat_out changes.
- done rises NUM_PATTERNS*(SETTLE_CYCLES+2) cycles after the start edge (1024 at defaults); busy falls on the same edge.
- signature/ones_count update on the CAPTURE edge, visible next cycle.
- resp_in is assumed synchronous to clk (combinational path from pat_out); no synchroniser.

## Test plan
- Reset: assert rst_n=0 mid-run -> all outputs 0 asynchronously, state IDLE; after release, seed register = 1.
- Default seed, resp_in tied 0, defaults -> done exactly 1024 cycles after start, signature=16'h0000, ones_count=0; first two pat_out values 27'h0000001, 27'h0000003.
- NUM_PATTERNS=1, resp_in tied 1 -> signature=16'h1021, ones_count=1, done after 4 cycles.
- seed_load with seed=0 then start -> first pat_out=27'h0000001; seed_load/start while busy -> ignored, run unaffected.
- Connect resp_in to pat_out[0] (loopback), defaults -> ones_count equals count of odd vectors from software LFSR model; signature matches model CRC.
- abort at cycle 100 of a run -> IDLE next edge, done=0, busy=0, ones_count holds partial value; subsequent start completes normally with fresh signature.

Source files
------------

// File: rtl/fake_netlist_pattern_driver_if.sv
// Bus between the pattern driver and whatever sits around it: run control,
// seed, the vector towards the netlist, its response and the run result.
interface fake_netlist_pattern_driver_if #(
    parameter int unsigned NUM_PATTERNS = 256
);
    localparam int unsigned CW = $clog2(NUM_PATTERNS + 1);

    logic          start;
    logic          abort;
    logic          seed_load;
    logic [26:0]   seed;
    logic [26:0]   pat_out;
    logic          resp_in;
    logic          busy;
    logic          done;
    logic [15:0]   signature;
    logic [CW-1:0] ones_count;

    // Controller / test side.
    modport master (
        output start, abort, seed_load, seed, resp_in,
        input  pat_out, busy, done, signature, ones_count
    );

    // Pattern driver side.
    modport slave (
        input  start, abort, seed_load, seed, resp_in,
        output pat_out, busy, done, signature, ones_count
    );
endinterface

// File: rtl/fake_netlist_pattern_driver.sv
// Sequential pattern driver for 27-in/1-out fake netlists: drives LFSR
// vectors, waits for the netlist to settle, compacts responses into a CRC-16.
module fake_netlist_pattern_driver #(
    parameter int unsigned NUM_PATTERNS  = 256,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    fake_netlist_pattern_driver_if.slave bus
);
    localparam int unsigned CW = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LastIdx    = CW'(NUM_PATTERNS - 1);
    localparam logic [SW-1:0] SettleInit = SW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StCapture, StDone} state_e;

    state_e        state_q, state_d;
    logic [26:0]   lfsr_q, lfsr_d;
    logic [26:0]   seed_q, seed_d;
    logic [26:0]   pat_q, pat_d;
    logic [15:0]   sig_q, sig_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;

    logic [26:0]   seed_eff;
    logic          idle_or_done;
    logic          fb;

    function automatic logic [26:0] lfsr_step(input logic [26:0] v);
        return {v[25:0], v[26] ^ v[4] ^ v[1] ^ v[0]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_eff     = (bus.seed == 27'h0) ? 27'h0000001 : bus.seed;
    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign fb           = sig_q[15] ^ bus.resp_in;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= 27'h0000001;
            seed_q   <= 27'h0000001;
            pat_q    <= '0;
            sig_q    <= '0;
            ones_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            pat_q    <= pat_d;
            sig_q    <= sig_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    // Next-state and datapath update; abort overrides everything incl. completion.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        pat_d    = pat_q;
        sig_d    = sig_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;

        if (idle_or_done && bus.seed_load) seed_d = seed_eff;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d = StApply;
                        // A coincident seed_load seeds this very run.
                        lfsr_d  = bus.seed_load ? seed_eff : seed_q;
                        sig_d   = '0;
                        ones_d  = '0;
                        cnt_d   = '0;
                    end
                end
                StApply: begin
                    pat_d    = lfsr_q;
                    settle_d = SettleInit;
                    state_d  = (SETTLE_CYCLES == 0) ? StCapture : StSettle;
                end
                StSettle: begin
                    settle_d = settle_q - 1'b1;
                    if (settle_q <= SW'(1)) state_d = StCapture;
                end
                StCapture: begin
                    sig_d  = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                    ones_d = ones_q + CW'(bus.resp_in);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StApply;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.pat_out    = pat_q;
    assign bus.signature  = sig_q;
    assign bus.ones_count = ones_q;
    assign bus.busy       = (state_q == StApply) || (state_q == StSettle) ||
                            (state_q == StCapture);
    assign bus.done       = (state_q == StDone);
endmodule

// File: tb/tb_fake_netlist_pattern_driver.sv
// Directed bench for fake_netlist_pattern_driver: a default instance (256
// vectors, 2 settle cycles) and a single-vector instance with resp_in tied 1.
module tb_fake_netlist_pattern_driver;
    logic clk;
    logic rst_n;
    logic loop_en;

    int n_vec;
    int n_err;

    fake_netlist_pattern_driver_if #(.NUM_PATTERNS(256)) bus ();
    fake_netlist_pattern_driver_if #(.NUM_PATTERNS(1))   bus1 ();

    fake_netlist_pattern_driver #(.NUM_PATTERNS(256), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fake_netlist_pattern_driver #(.NUM_PATTERNS(1), .SETTLE_CYCLES(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Response source: tied low, or looped back from pattern bit 0.
    assign bus.resp_in  = loop_en ? bus.pat_out[0] : 1'b0;
    assign bus1.resp_in = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] lfsr_step(input logic [26:0] v);
        return {v[25:0], v[26] ^ v[4] ^ v[1] ^ v[0]};
    endfunction

    // Loopback model: response of vector k is bit 0 of that vector.
    task automatic model_loop(input logic [26:0] seed, input int n,
                              output logic [15:0] sig, output int ones);
        logic [26:0] l;
        logic        r;
        l    = seed;
        sig  = '0;
        ones = 0;
        for (int k = 0; k < n; k++) begin
            r    = l[0];
            ones += int'(r);
            sig  = {sig[14:0], 1'b0} ^ ((sig[15] ^ r) ? 16'h1021 : 16'h0000);
            l    = lfsr_step(l);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (optionally with seed_load) for one edge; that edge is T0.
    task automatic do_start(input bit with_seed, input logic [26:0] s);
        bus.start     = 1'b1;
        bus.seed_load = with_seed;
        bus.seed      = s;
        tick();
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
    endtask

    // Count cycles after T0 until done; optionally poke start/seed_load mid-run.
    task automatic run_to_done(input bit inject, output int cyc,
                               output logic [26:0] p0, output logic [26:0] p1,
                               output logic b0);
        cyc = -1;
        p0  = '0;
        p1  = '0;
        b0  = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            tick();
            if (c == 1) begin
                p0 = bus.pat_out;
                b0 = bus.busy;
            end
            if (c == 5) p1 = bus.pat_out;
            if (inject && c == 20) begin
                bus.start     = 1'b1;
                bus.seed_load = 1'b1;
                bus.seed      = 27'h0001234;
            end
            if (inject && c == 21) begin
                bus.start     = 1'b0;
                bus.seed_load = 1'b0;
            end
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        int          ones_m;
        logic [15:0] sig_m;
        logic [26:0] p0, p1;
        logic        b0;

        n_vec          = 0;
        n_err          = 0;
        loop_en        = 1'b0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.seed_load  = 1'b0;
        bus.seed       = '0;
        bus1.start     = 1'b0;
        bus1.abort     = 1'b0;
        bus1.seed_load = 1'b0;
        bus1.seed      = '0;
        #22;
        rst_n = 1'b1;
        tick();

        check_eq("rst_pat_out", 32'(bus.pat_out), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        check_eq("rst_signature", 32'(bus.signature), 32'h0);
        check_eq("rst_ones", 32'(bus.ones_count), 32'h0);

        // Default seed, response tied low.
        do_start(1'b0, '0);
        run_to_done(1'b0, cyc, p0, p1, b0);
        check_eq("a_done_cycle", 32'(cyc), 32'd1024);
        check_eq("a_busy_early", 32'(b0), 32'h1);
        check_eq("a_pat0", 32'(p0), 32'h0000001);
        check_eq("a_pat1", 32'(p1), 32'h0000003);
        check_eq("a_busy_at_done", 32'(bus.busy), 32'h0);
        check_eq("a_signature", 32'(bus.signature), 32'h0);
        check_eq("a_ones", 32'(bus.ones_count), 32'h0);

        // Single vector, response tied high.
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (bus1.done) begin
                cyc = c;
                break;
            end
        end
        check_eq("b_done_cycle", 32'(cyc), 32'd4);
        check_eq("b_signature", 32'(bus1.signature), 32'h1021);
        check_eq("b_ones", 32'(bus1.ones_count), 32'h1);

        // Zero seed guarded to 1, loopback, start/seed_load ignored while busy.
        loop_en       = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed      = 27'h0;
        tick();
        bus.seed_load = 1'b0;
        do_start(1'b0, '0);
        run_to_done(1'b1, cyc, p0, p1, b0);
        model_loop(27'h0000001, 256, sig_m, ones_m);
        check_eq("c_pat0", 32'(p0), 32'h0000001);
        check_eq("c_done_cycle", 32'(cyc), 32'd1024);
        check_eq("c_ones", 32'(bus.ones_count), 32'(ones_m));
        check_eq("c_signature", 32'(bus.signature), 32'(sig_m));

        // seed_load coincident with start seeds that run.
        do_start(1'b1, 27'h5A5A5A5);
        run_to_done(1'b0, cyc, p0, p1, b0);
        model_loop(27'h5A5A5A5, 256, sig_m, ones_m);
        check_eq("d_pat0", 32'(p0), 32'h5A5A5A5);
        check_eq("d_pat1", 32'(p1), 32'(lfsr_step(27'h5A5A5A5)));
        check_eq("d_done_cycle", 32'(cyc), 32'd1024);
        check_eq("d_ones", 32'(bus.ones_count), 32'(ones_m));
        check_eq("d_signature", 32'(bus.signature), 32'(sig_m));

        // Abort after 100 cycles: 25 captures so far (edges 4, 8, .., 100).
        do_start(1'b0, '0);
        for (int c = 1; c <= 100; c++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        model_loop(27'h5A5A5A5, 25, sig_m, ones_m);
        check_eq("e_busy", 32'(bus.busy), 32'h0);
        check_eq("e_done", 32'(bus.done), 32'h0);
        check_eq("e_ones_partial", 32'(bus.ones_count), 32'(ones_m));
        check_eq("e_sig_partial", 32'(bus.signature), 32'(sig_m));
        for (int c = 0; c < 8; c++) tick();
        check_eq("e_ones_hold", 32'(bus.ones_count), 32'(ones_m));
        check_eq("e_done_hold", 32'(bus.done), 32'h0);
        do_start(1'b0, '0);
        run_to_done(1'b0, cyc, p0, p1, b0);
        model_loop(27'h5A5A5A5, 256, sig_m, ones_m);
        check_eq("e_rerun_cycle", 32'(cyc), 32'd1024);
        check_eq("e_rerun_sig", 32'(bus.signature), 32'(sig_m));
        check_eq("e_rerun_ones", 32'(bus.ones_count), 32'(ones_m));

        // Asynchronous reset mid-run, then seed register back to 1.
        bus.seed_load = 1'b1;
        bus.seed      = 27'h0000005;
        tick();
        bus.seed_load = 1'b0;
        do_start(1'b0, '0);
        for (int c = 1; c <= 50; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("r_pat_out", 32'(bus.pat_out), 32'h0);
        check_eq("r_busy", 32'(bus.busy), 32'h0);
        check_eq("r_done", 32'(bus.done), 32'h0);
        check_eq("r_signature", 32'(bus.signature), 32'h0);
        check_eq("r_ones", 32'(bus.ones_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start(1'b0, '0);
        run_to_done(1'b0, cyc, p0, p1, b0);
        check_eq("r_seed_pat0", 32'(p0), 32'h0000001);
        check_eq("r_seed_pat1", 32'(p1), 32'h0000003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
